qtps_alu_arbiter: RTL
=====================

Name: qtps_alu_arbiter

Overview:
- Shares the single scalar ALU between NUM_REQ requesters (e.g. main issue slot, loop/elevator sequencer).
- Grants one request per cycle with round-robin priority and drives the ALU combinationally.
- Captures the ALU result and flags in a one-entry registered response buffer with valid/ready backpressure.
- Maintains the architectural Z/C/V flag register.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DATA_WIDTH, qtpa_pkg::DATA_WIDTH, operand/result width.
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous: drop buffered response, suppress grant this cycle.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ×$bits(op_t)  packed op_t per requester; entry i at slice i.
- req_op1  in  NUM_REQ×DATA_WIDTH  packed op1 per requester.
- req_op2  in  NUM_REQ×DATA_WIDTH  packed op2 (register value or sign-extended immediate).
- alu_op  out  op_t  to ALU.
- alu_op1  out  DATA_WIDTH  to ALU.
- alu_op2  out  DATA_WIDTH  to ALU.
- alu_result  in  DATA_WIDTH  from ALU.
- alu_flag_zero / alu_flag_carry / alu_flag_ovf  in  1 each  from ALU.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  requester index of the buffered result.
- rsp_op  out  op_t  op of the buffered result (lets writeback route LCSET).
- rsp_result  out  DATA_WIDTH  buffered result.
- flags_z / flags_c / flags_v  out  1 each  architectural flag register.

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_op=default/NOP encoding, rsp_result=0, flags_z/c/v=0, RR pointer=0.
- can_accept = !flush && (!rsp_valid || rsp_ready).
- Arbitration, combinational:
  - Search requesters starting at the pointer, ascending with wrap at NUM_REQ-1→0.
  - The first requester with req_valid=1 wins (gnt).
  - req_ready[gnt]=1 only if can_accept; every other req_ready bit is 0.
- ALU drive:
  - alu_op/op1/op2 = winner's fields.
  - When there is no winner, they are the default op with zero operands, so the ALU outputs 0.
- Handshake: a transfer ("fire") occurs when req_valid[i] && req_ready[i].
  - Requesters must hold op, op1 and op2 stable while valid && !ready.
- On fire, at the clock edge:
  - rsp_valid=1; rsp_id=gnt; rsp_op=alu_op; rsp_result=alu_result.
  - Pointer = (gnt+1) mod NUM_REQ.
  - Latency: request fire at edge N gives rsp_valid=1 after edge N.
- No fire: pointer unchanged.
- Buffer:
  - rsp_valid && rsp_ready && no new fire → rsp_valid=0 next cycle.
  - Accept + new fire in the same cycle → back-to-back, rsp_valid stays 1 with the new data. Full throughput is 1 op/cycle.
  - rsp_valid && !rsp_ready → buffer holds all rsp_* fields, and no grants are issued.
- Flag register update on fire:
  - Flag-producing ops: ADD, SUB, AND, OR, CMP, MOV, SHL, SHR (IMM and REG forms). On fire of any of these, flags_z/c/v take the ALU flag outputs.
  - LCSET and unknown/default ops leave the flags unchanged.
  - The flag update is not subject to rsp_ready; it happens at the fire edge.
- CMP: produces a response (result 0) so the requester sees completion; flags update as above.
- Flush:
  - Next cycle rsp_valid=0.
  - No fire in the flush cycle (req_ready all 0).
  - Flags and pointer unchanged.
  - Flush has priority over a simultaneous rsp_ready.
- Reset mid-operation: all state returns to reset values immediately; any in-flight buffered response is lost.
- Single requester valid: it is granted every cycle regardless of pointer (subject to can_accept).
- Implementation: no combinational path from rsp_ready to alu_* outputs; only req_ready depends on rsp_ready.

Test Plan:
- Reset, then req 0 valid with ADD_REG 5+7 → req_ready[0]=1; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, flags z=0 c=0 v=0.
- Both requesters valid continuously, rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - rsp_valid stays 1 every cycle with the ids in that order.
- Hold rsp_ready=0 for 3 cycles with req 1 pending:
  - req_ready=0 throughout; rsp fields stable.
  - Raise rsp_ready → req 1 granted that cycle, its response visible next cycle.
- CMP_REG 3,3 then LCSET_IMM 9:
  - After CMP, flags_z=1 and rsp_result=0.
  - After LCSET, rsp_result=9, rsp_op=LCSET_IMM, flags_z still 1.
- SUB_REG 0x0-0x1 (DATA_WIDTH=16) → rsp_result=0xFFFF, flags_c=1, flags_z=0.
- Assert flush with rsp_valid=1 and req 0 valid → next cycle rsp_valid=0, no grant, pointer and flags unchanged.
- Assert rst asynchronously mid-stream → outputs and pointer go to reset values before the next edge.

Source files
------------

// File: rtl/qtps_alu_arbiter.sv
// qtpa_pkg: shared datapath width and the ALU opcode encoding.
// qtps_alu_arbiter: round-robin arbiter sharing one scalar ALU between
// NUM_REQ requesters, with a one-entry registered response buffer and the
// architectural Z/C/V flag register.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush                        drop buffered response, block grants this cycle
//   req_valid/req_ready          per-requester handshake (ready is one-hot or zero)
//   req_op/req_op1/req_op2       packed per-requester op and operands (slice i = requester i)
//   alu_op/alu_op1/alu_op2       drive to the shared ALU (winner's fields, else NOP/0)
//   alu_result, alu_flag_*       ALU outputs, captured on a grant
//   rsp_valid/rsp_ready          response buffer handshake
//   rsp_id/rsp_op/rsp_result     buffered response contents
//   flags_z/flags_c/flags_v      architectural flag register
package qtpa_pkg;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [4:0] {
        OP_NOP       = 5'd0,
        OP_ADD_IMM   = 5'd1,
        OP_ADD_REG   = 5'd2,
        OP_SUB_IMM   = 5'd3,
        OP_SUB_REG   = 5'd4,
        OP_AND_IMM   = 5'd5,
        OP_AND_REG   = 5'd6,
        OP_OR_IMM    = 5'd7,
        OP_OR_REG    = 5'd8,
        OP_CMP_IMM   = 5'd9,
        OP_CMP_REG   = 5'd10,
        OP_MOV_IMM   = 5'd11,
        OP_MOV_REG   = 5'd12,
        OP_SHL_IMM   = 5'd13,
        OP_SHL_REG   = 5'd14,
        OP_SHR_IMM   = 5'd15,
        OP_SHR_REG   = 5'd16,
        OP_LCSET_IMM = 5'd17
    } op_t;
endpackage

module qtps_alu_arbiter
    import qtpa_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = qtpa_pkg::DATA_WIDTH,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*$bits(op_t)-1:0] req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    output op_t                           alu_op,
    output logic [DATA_WIDTH-1:0]         alu_op1,
    output logic [DATA_WIDTH-1:0]         alu_op2,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_flag_zero,
    input  logic                          alu_flag_carry,
    input  logic                          alu_flag_ovf,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output op_t                           rsp_op,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          flags_z,
    output logic                          flags_c,
    output logic                          flags_v
);
    localparam int OPW = $bits(op_t);

    op_t                   w_op  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_op1 [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_op2 [NUM_REQ];

    logic [ID_W-1:0]       r_ptr;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    op_t                   r_rsp_op;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_flag_z, r_flag_c, r_flag_v;

    logic                  w_found;
    logic [ID_W-1:0]       w_gnt;
    logic                  w_can_accept;
    logic                  w_fire;

    // Only flag-producing ops write the architectural flags.
    function automatic logic is_flag_op(input op_t op);
        case (op)
            OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
            OP_AND_IMM, OP_AND_REG, OP_OR_IMM,  OP_OR_REG,
            OP_CMP_IMM, OP_CMP_REG, OP_MOV_IMM, OP_MOV_REG,
            OP_SHL_IMM, OP_SHL_REG, OP_SHR_IMM, OP_SHR_REG: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Unpack the per-requester fields and form the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_op[gi]      = op_t'(req_op[gi*OPW +: OPW]);
            assign w_op1[gi]     = req_op1[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_op2[gi]     = req_op2[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = w_found && w_can_accept && (w_gnt == ID_W'(gi));
        end
    endgenerate

    // Rotating search starting at the pointer; the first valid requester wins.
    // The winner does not depend on rsp_ready, so the ALU drive has no path
    // from the consumer's backpressure.
    always_comb begin
        logic [ID_W:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (v_idx >= (ID_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_can_accept = !flush && (!r_rsp_valid || rsp_ready);
    assign w_fire       = w_found && w_can_accept;

    assign alu_op  = w_found ? w_op[w_gnt]  : OP_NOP;
    assign alu_op1 = w_found ? w_op1[w_gnt] : '0;
    assign alu_op2 = w_found ? w_op2[w_gnt] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_op     <= OP_NOP;
            r_rsp_result <= '0;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
            r_flag_v     <= 1'b0;
        end else begin
            if (w_fire) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= w_gnt;
                r_rsp_op     <= alu_op;
                r_rsp_result <= alu_result;
                r_ptr        <= (w_gnt == ID_W'(NUM_REQ-1)) ? '0 : w_gnt + ID_W'(1);
                if (is_flag_op(alu_op)) begin
                    r_flag_z <= alu_flag_zero;
                    r_flag_c <= alu_flag_carry;
                    r_flag_v <= alu_flag_ovf;
                end
            end else if (flush || rsp_ready) begin
                // Flush wins over a held response; an accepted one drains.
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_op     = r_rsp_op;
    assign rsp_result = r_rsp_result;
    assign flags_z    = r_flag_z;
    assign flags_c    = r_flag_c;
    assign flags_v    = r_flag_v;
endmodule
